bin_conv_engine: RTL and testbench

BIN_CONV_ENGINE -- requirements
Module: bin_conv_engine

---
 rtl/bin_conv_engine.sv | 178 +++++++++++++++++
 tb/tb_bin_conv_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_conv_engine.sv
// rtl/bin_conv_engine.sv - binary-weight KxK convolution engine over a streamed square image
//
// Purpose: loads K*K serial binary weights (+1/-1), then streams an IMG_W x IMG_W
// signed image in raster order and emits one signed KxK window sum per valid
// window position, with optional ReLU clamp.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      level request to begin an image pass (taken in IDLE with weight_en=0)
//   relu_en    clamp negative results to 0, latched when start is taken
//   weight_en  serial weight bit present on weight
//   weight     binary weight, 1 = +1, 0 = -1
//   din_valid  pixel present on din
//   din        signed pixel, row-major raster order
//   din_ready  engine accepts a pixel this cycle
//   ovalid     dout holds a new result
//   dout       signed convolution result, held while ovalid=0
//   done       one-cycle pulse alongside the final result of a pass
module bin_conv_engine #(
  parameter int DIN_W = 32,
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int ACC_W = 37
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             relu_en,
  input  logic             weight_en,
  input  logic             weight,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  output logic             din_ready,
  output logic             ovalid,
  output logic [ACC_W-1:0] dout,
  output logic             done
);

  localparam int NW   = K * K;
  localparam int WCW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int NPIX = IMG_W * IMG_W;
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [WCW-1:0] W_LAST    = WCW'(NW - 1);
  localparam logic [PCW-1:0] P_TOTAL   = PCW'(NPIX);
  localparam logic [CW-1:0]  EDGE_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  WIN_FIRST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state, state_nxt;

  logic [NW-1:0]    wts;
  logic [WCW-1:0]   wcnt;
  logic [PCW-1:0]   pcnt;
  logic [CW-1:0]    row, col;
  logic             relu_q;
  logic             accept, in_window, last_pix;
  logic [DIN_W-1:0] line_buf [0:K-2][0:IMG_W-1];
  logic [DIN_W-1:0] win      [0:K-1][0:K-1];
  logic [DIN_W-1:0] win_nxt  [0:K-1][0:K-1];
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    case (state)
      IDLE: begin
        if (weight_en)  state_nxt = LOAD;
        else if (start) state_nxt = STREAM;
      end
      LOAD: begin
        if (weight_en && wcnt == W_LAST) state_nxt = IDLE;
      end
      STREAM: begin
        din_ready = (pcnt < P_TOTAL);
        // Leave on the edge that registers the final result, so done is seen in IDLE
        // and a still-high start can launch the next pass straight away.
        if (din_valid && din_ready && last_pix) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = din_valid && din_ready;
  assign in_window = (row >= WIN_FIRST) && (col >= WIN_FIRST);
  assign last_pix  = (row == EDGE_LAST) && (col == EDGE_LAST);

  // Window after this pixel: shift every row left, new right column is the K-1
  // buffered pixels above this column (oldest row first) plus the incoming pixel.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) win_nxt[i][j] = win[i][j+1];
    end
    for (int i = 0; i < K - 1; i++) win_nxt[i][K-1] = line_buf[i][col];
    win_nxt[K-1][K-1] = din;

    sum = '0;
    ext = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        ext = {{(ACC_W-DIN_W){win_nxt[i][j][DIN_W-1]}}, win_nxt[i][j]};
        if (wts[i*K+j]) sum = sum + ext;
        else            sum = sum - ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wts    <= '0;
      wcnt   <= '0;
      pcnt   <= '0;
      row    <= '0;
      col    <= '0;
      relu_q <= 1'b0;
      ovalid <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      for (int i = 0; i < K - 1; i++)
        for (int c = 0; c < IMG_W; c++) line_buf[i][c] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else begin
      ovalid <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (weight_en) begin
            wts[0] <= weight;
            wcnt   <= WCW'(1);
          end else if (start) begin
            relu_q <= relu_en;
            pcnt   <= '0;
            row    <= '0;
            col    <= '0;
          end
        end
        LOAD: begin
          if (weight_en) begin
            wts[wcnt] <= weight;
            wcnt      <= wcnt + 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            pcnt <= pcnt + 1'b1;
            if (col == EDGE_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++) win[i][j] <= win_nxt[i][j];
            // Each column slot acts as a K-1 deep shift register of earlier rows.
            for (int i = 0; i < K - 2; i++) line_buf[i][col] <= line_buf[i+1][col];
            line_buf[K-2][col] <= din;
            if (in_window) begin
              ovalid <= 1'b1;
              done   <= last_pix;
              dout   <= (relu_q && sum[ACC_W-1]) ? '0 : sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_conv_engine.sv
// tb/tb_bin_conv_engine.sv - self-checking bench for bin_conv_engine
module tb_bin_conv_engine;
  localparam int DW   = 32;
  localparam int IMG  = 28;
  localparam int K    = 5;
  localparam int AW   = 37;
  localparam int NPIX = IMG * IMG;
  localparam int NRES = (IMG - K + 1) * (IMG - K + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic          weight_en = 1'b0;
  logic          weight = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_ready, ovalid, done;
  logic [AW-1:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [DW-1:0] img [NPIX];
  logic [AW-1:0]        exp_q [$];
  logic [K*K-1:0]       cur_w;

  typedef struct {
    logic [K*K-1:0]       w;
    logic signed [DW-1:0] px;
    bit                   relu;
    bit                   gaps;
    longint               ev;
  } vec_t;
  vec_t vt [9];

  bin_conv_engine #(.DIN_W(DW), .IMG_W(IMG), .K(K), .ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .relu_en(relu_en),
    .weight_en(weight_en), .weight(weight), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .ovalid(ovalid), .dout(dout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fill_img(input logic signed [DW-1:0] px);
    for (int i = 0; i < NPIX; i++) img[i] = px;
  endtask

  task automatic fill_exp(input longint v);
    exp_q.delete();
    for (int i = 0; i < NRES; i++) exp_q.push_back(v[AW-1:0]);
  endtask

  // Direct 2-D convolution: weight bit n sits at window row n/K, column n%K.
  function automatic void build_model(input bit relu);
    longint s, p;
    exp_q.delete();
    for (int r = K - 1; r < IMG; r++) begin
      for (int c = K - 1; c < IMG; c++) begin
        s = 0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            p = img[(r - K + 1 + i) * IMG + (c - K + 1 + j)];
            s = cur_w[i*K+j] ? s + p : s - p;
          end
        end
        if (relu && s < 0) s = 0;
        exp_q.push_back(s[AW-1:0]);
      end
    end
  endfunction

  // Called at a negedge with the engine in IDLE.
  task automatic load_weights(input logic [K*K-1:0] w, input bit gaps);
    int n = 0;
    while (n < K * K) begin
      weight_en = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      weight    = weight_en ? w[n] : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (weight_en) n++;
    end
    weight_en = 1'b0;
    weight    = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_pass(input string tag, input bit relu, input bit gaps, input bit keep_start);
    int acc, nres, ndone, bad_time, bad_val, bad_ready, cyc, r, c;
    bit exp_ov, done_last;
    logic [AW-1:0] last_dout;
    acc = 0; nres = 0; ndone = 0; bad_time = 0; bad_val = 0; bad_ready = 0; cyc = 0;
    exp_ov = 1'b0; done_last = 1'b0; last_dout = dout;
    start = 1'b1;
    relu_en = relu;
    while (cyc < 4000) begin
      if (ovalid !== exp_ov) bad_time++;
      if (ovalid === 1'b1) begin
        if (nres >= NRES || dout !== exp_q[nres]) bad_val++;
        if (done === 1'b1) begin
          ndone++;
          if (nres == NRES - 1) done_last = 1'b1;
        end
        nres++;
        last_dout = dout;
      end else begin
        if (done === 1'b1) ndone++;
        if (dout !== last_dout) bad_val++;
      end
      if (nres >= NRES) break;
      if (!keep_start && cyc > 0) start = 1'b0;
      din_valid = gaps ? cyc[0] : 1'b1;
      din = (acc < NPIX) ? img[acc] : '0;
      if (din_ready === 1'b1 && acc >= NPIX) bad_ready++;
      exp_ov = 1'b0;
      if (din_valid && din_ready === 1'b1) begin
        r = acc / IMG;
        c = acc % IMG;
        exp_ov = (r >= K - 1) && (c >= K - 1);
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!keep_start) start = 1'b0;
    @(negedge clk);
    check({tag, " accepted"}, acc, NPIX);
    check({tag, " results"}, nres, NRES);
    check({tag, " ovalid_timing_errs"}, bad_time, 0);
    check({tag, " dout_errs"}, bad_val, 0);
    check({tag, " ready_overrun"}, bad_ready, 0);
    check({tag, " done_count"}, ndone, 1);
    check({tag, " done_on_last"}, done_last, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " din_ready"}, din_ready, 0);
    check({tag, " ovalid"}, ovalid, 0);
    check({tag, " done"}, done, 0);
    check({tag, " dout"}, dout, 0);
  endtask

  initial begin
    int acc, cyc;
    bit relu;

    vt[0] = '{25'h1FFFFFF, 32'sd1,         1'b0, 1'b0, 64'sd25};
    vt[1] = '{25'h0000000, 32'sd1,         1'b0, 1'b0, -64'sd25};
    vt[2] = '{25'h0000000, 32'sd1,         1'b1, 1'b0, 64'sd0};
    vt[3] = '{25'h0000001, 32'sd1,         1'b0, 1'b0, -64'sd23};
    vt[4] = '{25'h1FFFFFF, 32'sd1,         1'b0, 1'b1, 64'sd25};
    vt[5] = '{25'h1FFFFFF, -32'sd3,        1'b1, 1'b0, 64'sd0};
    vt[6] = '{25'h000001F, 32'sd7,         1'b0, 1'b1, -64'sd105};
    vt[7] = '{25'h1FFFFFF, 32'h7FFFFFFF,   1'b0, 1'b0, 64'sd53687091175};
    vt[8] = '{25'h0000000, 32'h80000000,   1'b1, 1'b0, 64'sd53687091200};

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      cur_w = vt[v].w;
      fill_img(vt[v].px);
      load_weights(vt[v].w, vt[v].gaps);
      fill_exp(vt[v].ev);
      run_pass($sformatf("vec%0d", v), vt[v].relu, vt[v].gaps, 1'b0);
    end

    for (int t = 0; t < 3; t++) begin
      cur_w = K*K'($urandom);
      for (int i = 0; i < NPIX; i++)
        img[i] = (t == 0) ? DW'($urandom_range(0, 200)) - 32'sd100 : DW'($urandom);
      relu = t[0];
      load_weights(cur_w, 1'b1);
      build_model(relu);
      run_pass($sformatf("rand%0d", t), relu, ($urandom_range(0, 1) == 1), 1'b0);
    end
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom_range(0, 2000)) - 32'sd1000;
    build_model(1'b0);
    run_pass("retained_w", 1'b0, 1'b0, 1'b0);

    cur_w = K*K'($urandom);
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
    load_weights(cur_w, 1'b0);
    build_model(1'b1);
    run_pass("start_held", 1'b1, 1'b0, 1'b1);
    check("restart_after_done din_ready", din_ready, 1);
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
    build_model(1'b1);
    run_pass("second_pass", 1'b1, 1'b0, 1'b0);

    cur_w = '1;
    load_weights(cur_w, 1'b0);
    fill_img(32'sd1);
    start = 1'b1;
    relu_en = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 300 && cyc < 2000) begin
      din_valid = 1'b1;
      din = 32'sd1;
      if (din_ready === 1'b1) acc++;
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_stream accepted", acc, 300);
    check("mid_stream dout_before_rst", dout, 25);
    rstn = 1'b0;
    din_valid = 1'b0;
    #1;
    check_reset_outputs("mid_stream_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    fill_exp(-64'sd25);
    run_pass("cleared_w", 1'b0, 1'b0, 1'b0);
    load_weights(cur_w, 1'b0);
    fill_exp(64'sd25);
    run_pass("after_reload", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      weight_en = 1'b1;
      weight = 1'b1;
      @(negedge clk);
    end
    rstn = 1'b0;
    weight_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_load idle din_ready", din_ready, 0);
    fill_exp(-64'sd25);
    run_pass("mid_load_cleared", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
